// File: rtl/uart_cmd_host.sv
// Host-side initiator: sends one command byte over the UART transmitter, then waits
// for the reply with timeout and bounded retries. Define CMD_ECHO_EN to expect a command echo first.
module uart_cmd_host #(
   parameter int TimeoutCycles = 10000000,
   parameter int TimeoutWidth  = 24,
   parameter int Retries       = 2,
   parameter int CntWidth      = 8
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                req_i,
   input  logic [7:0]          cmd_i,
   output logic                tx_start_o,
   output logic [7:0]          tx_data_o,
   input  logic                tx_eot_i,
   input  logic                rx_eor_i,
   input  logic [7:0]          rx_data_i,
   output logic [7:0]          rsp_data_o,
   output logic                rsp_valid_o,
   output logic                busy_o,
   output logic                timeout_o,
   output logic [CntWidth-1:0] fail_cnt_o
);

   // state     | meaning
   // IDLE      | waiting for req_i
   // SEND      | one-cycle start pulse to the transmitter
   // WAIT_EOT  | command frame in flight
   // WAIT_RSP  | response window open (no echo build)
   // WAIT_ECHO | response window open, expecting the command echo
   // WAIT_DATA | echo matched, expecting the data byte in the same window
   // DONE      | response published
   // FAIL      | all attempts exhausted
   typedef enum logic [2:0] {
      IDLE,
      SEND,
      WAIT_EOT,
`ifdef CMD_ECHO_EN
      WAIT_ECHO,
      WAIT_DATA,
`else
      WAIT_RSP,
`endif
      DONE,
      FAIL
   } state_t;

   localparam int RetryWidth = (Retries < 1) ? 1 : $clog2(Retries + 1);
   localparam logic [RetryWidth-1:0]   RetryMax = RetryWidth'(Retries);
   localparam logic [TimeoutWidth-1:0] TmoLast  = TimeoutWidth'(TimeoutCycles - 1);

   state_t                  state_q, state_d;
   logic [RetryWidth-1:0]   retry_q;
   logic [TimeoutWidth-1:0] tmo_q;
   logic                    load_cmd, clr_tmo, inc_tmo, inc_retry, cap_rsp, attempt_over;
   logic                    tmo_hit;

   assign tmo_hit = (tmo_q == TmoLast);

   always_comb begin
      state_d      = state_q;
      load_cmd     = 1'b0;
      clr_tmo      = 1'b0;
      inc_tmo      = 1'b0;
      inc_retry    = 1'b0;
      cap_rsp      = 1'b0;
      attempt_over = 1'b0;
      tx_start_o   = 1'b0;
      rsp_valid_o  = 1'b0;
      timeout_o    = 1'b0;
      busy_o       = 1'b1;
      case (state_q)
         IDLE: begin
            busy_o = 1'b0;
            if (req_i) begin
               load_cmd = 1'b1;
               state_d  = SEND;
            end
         end
         SEND: begin
            tx_start_o = 1'b1;
            state_d    = WAIT_EOT;
         end
         // the link is half-duplex, so anything received while sending is discarded
         WAIT_EOT: begin
            if (tx_eot_i) begin
               clr_tmo = 1'b1;
`ifdef CMD_ECHO_EN
               state_d = WAIT_ECHO;
`else
               state_d = WAIT_RSP;
`endif
            end
         end
`ifdef CMD_ECHO_EN
         WAIT_ECHO: begin
            inc_tmo = 1'b1;
            if (rx_eor_i && (rx_data_i == tx_data_o)) state_d = WAIT_DATA;
            else if (rx_eor_i || tmo_hit)             attempt_over = 1'b1;
         end
         WAIT_DATA: begin
`else
         WAIT_RSP: begin
`endif
            inc_tmo = 1'b1;
            if (rx_eor_i) begin
               cap_rsp = 1'b1;
               state_d = DONE;
            end else if (tmo_hit) begin
               attempt_over = 1'b1;
            end
         end
         DONE: begin
            busy_o      = 1'b0;
            rsp_valid_o = 1'b1;
            state_d     = IDLE;
         end
         FAIL: begin
            busy_o    = 1'b0;
            timeout_o = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (attempt_over) begin
         if (retry_q < RetryMax) begin
            inc_retry = 1'b1;
            state_d   = SEND;
         end else begin
            state_d = FAIL;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         tx_data_o  <= '0;
         retry_q    <= '0;
         tmo_q      <= '0;
         rsp_data_o <= '0;
         fail_cnt_o <= '0;
      end else begin
         state_q <= state_d;
         if (load_cmd) begin
            tx_data_o <= cmd_i;
            retry_q   <= '0;
         end else if (inc_retry) begin
            retry_q <= retry_q + 1'b1;
         end
         if (clr_tmo)      tmo_q <= '0;
         else if (inc_tmo) tmo_q <= tmo_q + 1'b1;
         if (cap_rsp) rsp_data_o <= rx_data_i;
         if ((state_q == FAIL) && (fail_cnt_o != '1)) fail_cnt_o <= fail_cnt_o + 1'b1;
      end
   end

endmodule

// File: tb/tb_uart_cmd_host.sv
// Randomized bench for uart_cmd_host: a transaction-level model predicts attempts,
// response/timeout timing, the last good byte and the saturating failure count.
module tb_uart_cmd_host;
   localparam int TC = 100;
   localparam int RT = 2;
`ifdef CMD_ECHO_EN
   localparam bit Echo = 1'b1;
`else
   localparam bit Echo = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req = 1'b0;
   logic [7:0] cmd = 8'h00;
   logic       eot = 1'b0;
   logic       eor = 1'b0;
   logic [7:0] rxd = 8'h00;
   logic       tx_start, rsp_valid, busy, timeout;
   logic [7:0] tx_data, rsp_data, fail_cnt;

   logic       sat_req = 1'b0;
   logic       sat_start, sat_valid, sat_busy, sat_tmo;
   logic [7:0] sat_txd, sat_rsp, sat_fail;

   int vectors = 0;
   int miscompares = 0;
   int n_start = 0, n_valid = 0, n_tmo = 0;
   logic [7:0] m_rsp = 8'h00;
   int m_fail = 0;

   always #5 clk = ~clk;

   uart_cmd_host #(.TimeoutCycles(TC), .TimeoutWidth(8), .Retries(RT), .CntWidth(8)) u_dut (
      .clk_i(clk), .rst_i(rst), .req_i(req), .cmd_i(cmd),
      .tx_start_o(tx_start), .tx_data_o(tx_data), .tx_eot_i(eot),
      .rx_eor_i(eor), .rx_data_i(rxd),
      .rsp_data_o(rsp_data), .rsp_valid_o(rsp_valid), .busy_o(busy),
      .timeout_o(timeout), .fail_cnt_o(fail_cnt)
   );

   // minimal window and one retry, used for fast failure-counter saturation
   uart_cmd_host #(.TimeoutCycles(1), .TimeoutWidth(2), .Retries(1), .CntWidth(8)) u_sat (
      .clk_i(clk), .rst_i(rst), .req_i(sat_req), .cmd_i(8'hC3),
      .tx_start_o(sat_start), .tx_data_o(sat_txd), .tx_eot_i(1'b1),
      .rx_eor_i(1'b0), .rx_data_i(8'h00),
      .rsp_data_o(sat_rsp), .rsp_valid_o(sat_valid), .busy_o(sat_busy),
      .timeout_o(sat_tmo), .fail_cnt_o(sat_fail)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, $time / 10);
      end
   endtask

   task automatic step();
      @(negedge clk);
      n_start += int'(tx_start);
      n_valid += int'(rsp_valid);
      n_tmo   += int'(timeout);
   endtask

   // resp_at: attempt index that answers (RT+1 = none); k: data delay after eot;
   // mask: attempts that answer with a wrong echo (echo build only); stray: noise inputs
   task automatic run_txn(input logic [7:0] c, input int resp_at, input int k,
                          input logic [7:0] d, input bit stray, input int mask);
      int s_start, s_valid, s_tmo;
      s_start = n_start; s_valid = n_valid; s_tmo = n_tmo;
      check("idle_busy", busy, 0);
      cmd = c; req = 1'b1;
      step();
      req = 1'b0; cmd = $urandom;
      for (int a = 0; a <= RT; a++) begin
         int d_eot, s_at, ke, wt;
         bit bad;
         check("start", tx_start, 1);
         check("tx_data", tx_data, c);
         check("busy_send", busy, 1);
         d_eot = $urandom_range(1, 4);
         s_at  = stray ? $urandom_range(1, d_eot) : 0;
         step();
         for (int j = 1; j <= d_eot; j++) begin
            if (j == s_at) begin eor = 1'b1; rxd = Echo ? c : $urandom; end
            if (j == d_eot) eot = 1'b1;
            step();
            eor = 1'b0; eot = 1'b0;
         end
         if (a == resp_at) begin
            ke = Echo ? $urandom_range(1, k - 1) : 0;
            for (int t = 1; t <= k; t++) begin
               if (t == k) begin eor = 1'b1; rxd = d; end
               else if (t == ke) begin eor = 1'b1; rxd = c; end
               step();
               eor = 1'b0;
            end
            check("rsp_valid", rsp_valid, 1);
            check("rsp_data", rsp_data, d);
            check("busy_done", busy, 0);
            check("no_timeout", timeout, 0);
            m_rsp = d;
            step();
            break;
         end else begin
            bad = Echo && mask[a];
            wt  = bad ? $urandom_range(1, TC) : TC;
            for (int t = 1; t <= wt; t++) begin
               if (bad && t == wt) begin eor = 1'b1; rxd = c ^ 8'h01; end
               if (stray && t == 1) begin req = 1'b1; cmd = ~c; end
               step();
               eor = 1'b0; req = 1'b0;
            end
            if (a == RT) begin
               check("timeout", timeout, 1);
               check("busy_fail", busy, 0);
               check("no_valid", rsp_valid, 0);
               m_fail = (m_fail < 255) ? m_fail + 1 : 255;
               step();
            end
         end
      end
      check("n_start", n_start - s_start, (resp_at <= RT) ? resp_at + 1 : RT + 1);
      check("n_valid", n_valid - s_valid, (resp_at <= RT) ? 1 : 0);
      check("n_tmo", n_tmo - s_tmo, (resp_at <= RT) ? 0 : 1);
      check("rsp_hold", rsp_data, m_rsp);
      check("fail_cnt", fail_cnt, m_fail);
      check("end_busy", busy, 0);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int kmin, s_start, s_valid, s_tmo, got;
      kmin = Echo ? 2 : 1;
      repeat (3) step();
      check("rst_outs", {tx_start, tx_data, rsp_valid, rsp_data, busy, timeout, fail_cnt}, 0);
      rst = 1'b0;
      step();
      check("post_rst_outs", {tx_start, tx_data, rsp_valid, rsp_data, busy, timeout, fail_cnt}, 0);

      run_txn(8'h41, 0, 20, 8'h5A, 1'b0, 0);
      run_txn(8'h42, RT + 1, 0, 8'h00, 1'b0, 0);
      run_txn(8'h43, 1, 35, 8'h33, 1'b0, 0);
      run_txn(8'h44, 0, TC, 8'hA5, 1'b1, 0);
      run_txn(8'h45, 2, kmin, 8'h3C, 1'b1, 0);
      run_txn(8'h41, 0, 10, 8'h07, 1'b0, 0);
      run_txn(8'h41, 1, 10, 8'h07, 1'b0, 1);
      run_txn(8'h46, RT + 1, 0, 8'h00, 1'b1, 7);

      for (int i = 0; i < 14; i++) begin
         int ra, r, kk;
         ra = $urandom_range(0, RT + 1);
         r  = $urandom_range(0, 3);
         kk = (r == 0) ? kmin : (r == 1) ? TC : $urandom_range(kmin, TC);
         run_txn(8'($urandom), ra, kk, 8'($urandom), 1'($urandom), $urandom_range(0, 7));
      end

      // reset in the response window: abort without pulses, counters back to zero
      cmd = 8'h99; req = 1'b1;
      step();
      req = 1'b0;
      step();
      eot = 1'b1;
      step();
      eot = 1'b0;
      repeat (5) step();
      check("pre_rst_busy", busy, 1);
      rst = 1'b1;
      s_start = n_start; s_valid = n_valid; s_tmo = n_tmo;
      step();
      check("mid_rst_outs", {tx_start, tx_data, rsp_valid, rsp_data, busy, timeout, fail_cnt}, 0);
      step();
      rst = 1'b0;
      repeat (3) step();
      check("rst_pulses", (n_start - s_start) + (n_valid - s_valid) + (n_tmo - s_tmo), 0);
      check("after_rst_outs", {tx_start, tx_data, rsp_valid, rsp_data, busy, timeout, fail_cnt}, 0);
      m_rsp = 8'h00; m_fail = 0;
      run_txn(8'h41, 0, 20, 8'h5A, 1'b0, 0);

      // 2**8+3 consecutive failures must leave the counter pinned at all-ones
      for (int i = 0; i < 259; i++) begin
         sat_req = 1'b1;
         step();
         sat_req = 1'b0;
         got = 0;
         for (int w = 0; w < 20 && got == 0; w++) begin
            step();
            if (sat_tmo) got = 1;
         end
         check("sat_timeout_seen", got, 1);
         step();
         check("sat_fail_cnt", sat_fail, (i + 1 < 255) ? i + 1 : 255);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
